wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the pipeline WB stage (MEM_WB outputs after the MemtoReg mux);
  - a long-latency multiply/divide (MD) unit that returns results out of band.
- The WB stage has priority. MD results queue in a small tagged buffer and drain on idle WB cycles.
- A starvation counter freezes the pipeline for one cycle when the queue is denied too long.
- Stale queued results are killed when a newer WB write targets the same register.

Parameters:
- RWIDTH, 5, register-specifier width
- WORD, 32, data width
- DEPTH, 4, MD result queue entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive denied cycles before a forced drain (>=1)

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- WB_RegWrite  input  1  WB stage requests a write
- WB_Write_reg  input  RWIDTH  WB destination register
- WB_Write_data  input  WORD  WB write data
- MD_Valid  input  1  MD unit presents a result
- MD_Write_reg  input  RWIDTH  MD destination register
- MD_Write_data  input  WORD  MD result
- MD_Ready  output  1  result accepted this cycle when MD_Valid is high
- RF_RegWrite  output  1  register-file write enable
- RF_Write_reg  output  RWIDTH  register-file write address
- RF_Write_data  output  WORD  register-file write data
- Pipe_Stall  output  1  freezes IF..MEM_WB for one cycle (registered)

Behaviour:
- Reset (synchronous):
  - queue empty, all entry valid bits 0, starve counter 0, Pipe_Stall 0;
  - while Reset is high, RF_RegWrite=0 and MD_Ready=0.
- RF_* and MD_Ready are combinational from the current state and inputs. The queue, counter and Pipe_Stall are registered.
- Queue entry = {valid, reg, data}; it is a FIFO with head/tail pointers and a count.
- MD_Ready = (count < DEPTH).
- Accept = MD_Valid & MD_Ready.
- Definitions: wb_req = WB_RegWrite & (WB_Write_reg != 0) & ~Pipe_Stall.
- Grant priority each cycle:
  1. Pipe_Stall=1: WB ignored (the frozen pipeline re-presents the instruction next cycle). Head is written if valid.
  2. wb_req: RF_* = WB inputs.
  3. Head present and valid: RF_* = head; head popped.
  4. count==0 and Accept: bypass; RF_* = MD inputs, nothing enqueued.
  5. Otherwise RF_RegWrite=0. RF_Write_reg/data are don't-care but driven to the WB inputs.
- Invalid (killed) head:
  - popped every cycle with no write, whatever the grant;
  - the port may still serve WB in that cycle;
  - rule 4 still requires count==0 at the start of the cycle.
- Accepted MD result not bypassed: enqueued at the tail the same cycle. Simultaneous pop and push are allowed when full, but MD_Ready stays from count, so no push when count==DEPTH.
- Register 0:
  - RF_RegWrite is never asserted for address 0;
  - MD results for reg 0 are accepted and discarded (not enqueued, no write).
- Kill: a granted WB write to R clears valid on every queued entry with reg==R. An MD result accepted in the same cycle counts as younger and is enqueued valid (or bypassed).
- Starve counter:
  - increments when count>0 and WB is granted;
  - clears when the head is written or the queue is empty.
  - On reaching STARVE_LIMIT, Pipe_Stall=1 next cycle for exactly one cycle and the counter clears.
  - Pipe_Stall never asserts on two consecutive cycles.
- Reset mid-operation: queued results are discarded. The MD unit must reissue, which is the system rule.

Decomposition:
- Package wb_arb_pkg holds RWIDTH, WORD, DEPTH and the queue entry struct/typedef (valid, reg, data).
- One sub-module, md_result_queue, holds the FIFO storage, pointers and count, plus a per-entry kill-by-register port.
- Grant logic and the starve counter stay in wb_write_arbiter.

Test Plan:
- Idle WB, MD_Valid reg=5 data=0x11 → RF write (5, 0x11) same cycle, MD_Ready=1, count stays 0.
- WB writes reg 3 on 3 consecutive cycles while MD delivers reg 7 (0xA), reg 8 (0xB) → both queued. On the first WB-idle cycle, RF writes (7, 0xA), then (8, 0xB) next cycle.
- Queue holds reg 9 = 0x1, then WB writes reg 9 = 0x2 → entry killed. The final RF sequence contains only (9, 0x2). The head is popped without a write.
- WB_RegWrite held high 8 cycles with one queued entry (reg 4) → Pipe_Stall=1 on cycle 9 for one cycle, RF writes reg 4 that cycle, then WB resumes.
- Fill the queue with 4 entries under continuous WB → MD_Ready=0. MD_Valid held stays pending, then is accepted the cycle after the first pop.
- MD result for reg 0 → accepted, no RF_RegWrite. WB write to reg 0 → no RF write and the queue drains instead. Reset asserted with 3 queued entries → next cycle count=0, RF_RegWrite=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths and the MD result queue entry for the WB write arbiter
package wb_arb_pkg;
    localparam int RWIDTH = 5;
    localparam int WORD = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);
    typedef struct packed {
        logic valid;
        logic [RWIDTH-1:0] wreg;
        logic [WORD-1:0] data;
    } md_entry_t;
endpackage

// File: rtl/md_result_queue.sv
// md_result_queue: FIFO of MD results with per-entry kill by destination register
module md_result_queue
    import wb_arb_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic [RWIDTH-1:0] push_reg,
    input  logic [WORD-1:0]   push_data,
    input  logic              pop,
    input  logic              kill,
    input  logic [RWIDTH-1:0] kill_reg,
    output md_entry_t         head,
    output logic [CW-1:0]     count
);
    localparam int PW = $clog2(DEPTH);
    md_entry_t mem [DEPTH];
    logic [PW-1:0] hd, tl;
    assign head = mem[hd];
    // the push follows the kill so a same-cycle result survives as the younger write
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hd <= '0;
            tl <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill && mem[i].wreg == kill_reg) mem[i].valid <= 1'b0;
            if (push) begin
                mem[tl] <= '{valid: 1'b1, wreg: push_reg, data: push_data};
                tl <= tl + PW'(1);
            end
            if (pop) hd <= hd + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between the WB stage and queued MD results
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WB_RegWrite,
    input  logic [RWIDTH-1:0] WB_Write_reg,
    input  logic [WORD-1:0]   WB_Write_data,
    input  logic              MD_Valid,
    input  logic [RWIDTH-1:0] MD_Write_reg,
    input  logic [WORD-1:0]   MD_Write_data,
    output logic              MD_Ready,
    output logic              RF_RegWrite,
    output logic [RWIDTH-1:0] RF_Write_reg,
    output logic [WORD-1:0]   RF_Write_data,
    output logic              Pipe_Stall
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    md_entry_t head;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic wb_req, empty, accept, head_wr, bypass, md_nz, bypass_wr, push, pop;
    assign wb_req = WB_RegWrite & (WB_Write_reg != '0) & ~Pipe_Stall;
    assign empty = count == '0;
    assign MD_Ready = ~Reset & (count < CW'(DEPTH));
    assign accept = MD_Valid & MD_Ready;
    assign md_nz = MD_Write_reg != '0;
    assign head_wr = ~empty & head.valid & ~wb_req;
    assign bypass = empty & ~wb_req & accept;
    assign bypass_wr = bypass & md_nz;
    assign push = accept & md_nz & ~bypass;
    // killed heads leave every cycle, even when WB owns the port
    assign pop = ~empty & (head_wr | ~head.valid);
    assign RF_RegWrite = ~Reset & (wb_req | head_wr | bypass_wr);
    assign RF_Write_reg = head_wr ? head.wreg : bypass_wr ? MD_Write_reg : WB_Write_reg;
    assign RF_Write_data = head_wr ? head.data : bypass_wr ? MD_Write_data : WB_Write_data;
    md_result_queue u_queue (
        .Clock    (Clock),
        .Reset    (Reset),
        .push     (push),
        .push_reg (MD_Write_reg),
        .push_data(MD_Write_data),
        .pop      (pop),
        .kill     (wb_req),
        .kill_reg (WB_Write_reg),
        .head     (head),
        .count    (count)
    );
    // a stall cycle blocks wb_req, so stalls can never come back to back
    always_ff @(posedge Clock) begin
        if (Reset) begin
            starve <= '0;
            Pipe_Stall <= 1'b0;
        end else begin
            Pipe_Stall <= 1'b0;
            if (empty || head_wr) starve <= '0;
            else if (wb_req) begin
                if (starve == SW'(STARVE_LIMIT - 1)) begin
                    starve <= '0;
                    Pipe_Stall <= 1'b1;
                end else starve <= starve + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed vectors with hand-computed expected RF writes, stalls and readiness
module tb_wb_write_arbiter;
    logic        Clock;
    logic        Reset;
    logic        WB_RegWrite;
    logic [4:0]  WB_Write_reg;
    logic [31:0] WB_Write_data;
    logic        MD_Valid;
    logic [4:0]  MD_Write_reg;
    logic [31:0] MD_Write_data;
    logic        MD_Ready;
    logic        RF_RegWrite;
    logic [4:0]  RF_Write_reg;
    logic [31:0] RF_Write_data;
    logic        Pipe_Stall;
    int n_tests = 0;
    int n_fail = 0;

    wb_write_arbiter dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .WB_RegWrite  (WB_RegWrite),
        .WB_Write_reg (WB_Write_reg),
        .WB_Write_data(WB_Write_data),
        .MD_Valid     (MD_Valid),
        .MD_Write_reg (MD_Write_reg),
        .MD_Write_data(MD_Write_data),
        .MD_Ready     (MD_Ready),
        .RF_RegWrite  (RF_RegWrite),
        .RF_Write_reg (RF_Write_reg),
        .RF_Write_data(RF_Write_data),
        .Pipe_Stall   (Pipe_Stall)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        WB_RegWrite = wb;
        WB_Write_reg = wr;
        WB_Write_data = wd;
        MD_Valid = mv;
        MD_Write_reg = mr;
        MD_Write_data = md;
        #2;
    endtask

    task automatic rf(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, "_we"}, RF_RegWrite, we);
        if (we) begin
            check({tag, "_reg"}, RF_Write_reg, r);
            check({tag, "_data"}, RF_Write_data, d);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1, 3, 32'h1, 1, 5, 32'h2);
        check("rst_rfwe", RF_RegWrite, 0);
        check("rst_ready", MD_Ready, 0);
        tick;
        check("rst_stall", Pipe_Stall, 0);
        Reset = 1'b0;
        // bypass on idle WB
        drive(0, 0, 0, 1, 5, 32'h11);
        check("byp_ready", MD_Ready, 1);
        rf("byp", 1, 5, 32'h11);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rf("byp_empty", 0, 0, 0);
        tick;
        // two MD results queue behind WB then drain in order
        drive(1, 3, 32'h30, 1, 7, 32'hA);
        rf("q_wb0", 1, 3, 32'h30);
        tick;
        drive(1, 3, 32'h31, 1, 8, 32'hB);
        rf("q_wb1", 1, 3, 32'h31);
        tick;
        drive(1, 3, 32'h32, 0, 0, 0);
        rf("q_wb2", 1, 3, 32'h32);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rf("q_d7", 1, 7, 32'hA);
        tick;
        rf("q_d8", 1, 8, 32'hB);
        tick;
        rf("q_done", 0, 0, 0);
        tick;
        // stale reg 9 killed by newer WB write
        drive(1, 2, 32'h20, 1, 9, 32'h1);
        rf("k_wb2", 1, 2, 32'h20);
        tick;
        drive(1, 9, 32'h2, 0, 0, 0);
        rf("k_wb9", 1, 9, 32'h2);
        tick;
        drive(0, 0, 0, 1, 10, 32'h55);
        rf("k_pop_nowr", 0, 0, 0);
        check("k_ready", MD_Ready, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rf("k_d10", 1, 10, 32'h55);
        tick;
        rf("k_done", 0, 0, 0);
        tick;
        // starvation forces one stall cycle
        drive(1, 3, 32'h40, 1, 4, 32'h44);
        rf("s_wb0", 1, 3, 32'h40);
        tick;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 3, 32'(i), 0, 0, 0);
            rf("s_wb", 1, 3, 32'(i));
            check("s_nostall", Pipe_Stall, 0);
            tick;
        end
        drive(1, 3, 32'h99, 0, 0, 0);
        check("s_stall", Pipe_Stall, 1);
        rf("s_d4", 1, 4, 32'h44);
        tick;
        check("s_unstall", Pipe_Stall, 0);
        rf("s_wbres", 1, 3, 32'h99);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rf("s_done", 0, 0, 0);
        tick;
        // fill the queue, back-pressure, then accept after the first pop
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 32'h50 + 32'(i), 1, 5'(11 + i), 32'hB1 + 32'(i));
            check("f_ready", MD_Ready, 1);
            rf("f_wb", 1, 3, 32'h50 + 32'(i));
            tick;
        end
        drive(1, 3, 32'h60, 1, 15, 32'h5F);
        check("f_full", MD_Ready, 0);
        tick;
        drive(0, 0, 0, 1, 15, 32'h5F);
        check("f_full_pop", MD_Ready, 0);
        rf("f_d11", 1, 11, 32'hB1);
        tick;
        check("f_accept", MD_Ready, 1);
        rf("f_d12", 1, 12, 32'hB2);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rf("f_d13", 1, 13, 32'hB3);
        tick;
        rf("f_d14", 1, 14, 32'hB4);
        tick;
        rf("f_d15", 1, 15, 32'h5F);
        tick;
        rf("f_done", 0, 0, 0);
        tick;
        // register 0 from either source never writes
        drive(0, 0, 0, 1, 0, 32'h77);
        check("z_ready", MD_Ready, 1);
        rf("z_md0", 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rf("z_md0_gone", 0, 0, 0);
        tick;
        drive(1, 3, 32'h33, 1, 6, 32'h66);
        rf("z_wb3", 1, 3, 32'h33);
        tick;
        drive(1, 0, 32'hEE, 0, 0, 0);
        rf("z_wb0_drain", 1, 6, 32'h66);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        rf("z_done", 0, 0, 0);
        tick;
        // reset discards queued results
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 32'h70 + 32'(i), 1, 5'(16 + i), 32'hC0 + 32'(i));
            rf("r_wb", 1, 3, 32'h70 + 32'(i));
            tick;
        end
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        rf("r_inrst", 0, 0, 0);
        check("r_ready", MD_Ready, 0);
        tick;
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rf("r_empty", 0, 0, 0);
        check("r_stall", Pipe_Stall, 0);
        drive(0, 0, 0, 1, 19, 32'hD9);
        rf("r_byp", 1, 19, 32'hD9);
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
